// File: rtl/collision_event_arbiter_if.sv
// Event handshake bundle between collision_event_arbiter (master) and its consumer.
interface collision_event_arbiter_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/collision_event_arbiter.sv
// collision_event_arbiter: turns eight per-pixel collision sources into at most
// one event per source per frame, queued as pending bits and presented one at a
// time through a valid/ready handshake, lowest source index first.
// Optional feature: define COLL_DROP_COUNT_EN to build the saturating counter of
// hits that arrived while the same source still had an unaccepted event.
module collision_event_arbiter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       towerPlayerCollision,
  input  logic       TowerEnemyHUCollision,
  input  logic [2:0] ShotEnemyCollision,
  input  logic [2:0] ShotBoxCollision,
  collision_event_arbiter_if.master evt,
  output logic [7:0] frame_hit_mask,
  output logic [7:0] last_frame_mask,
  output logic [7:0] drop_count
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHOW = 1'b1} state_t;

  // Index of the lowest set bit; the caller guarantees vec is non-zero.
  function automatic logic [2:0] lowest_index(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [7:0] src_s;
  logic [7:0] new_hit_s;
  logic [7:0] clear_s;
  logic [7:0] pending_nxt_s;
  logic       accept_s;
  logic [7:0] fired_r;
  logic [7:0] last_r;
  logic [7:0] pending_r;
  state_t     state_r;
  state_t     state_nxt_s;
  logic       valid_r;
  logic [2:0] code_r;
  logic [2:0] code_nxt_s;

  assign src_s = {ShotBoxCollision, ShotEnemyCollision, TowerEnemyHUCollision, towerPlayerCollision};
  // A hit coinciding with startOfFrame belongs to the new frame, so it is always new.
  assign new_hit_s     = src_s & (~fired_r | {8{startOfFrame}});
  assign accept_s      = valid_r & evt.evt_ready;
  assign clear_s       = accept_s ? (8'd1 << code_r) : 8'd0;
  // Set wins over clear so a re-hit of the accepted source stays pending.
  assign pending_nxt_s = (pending_r & ~clear_s) | new_hit_s;

  // Per-frame hit tracking and snapshot of the finished frame.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      fired_r <= 8'd0;
      last_r  <= 8'd0;
    end else if (startOfFrame) begin
      last_r  <= fired_r;
      fired_r <= src_s;
    end else begin
      fired_r <= fired_r | src_s;
    end
  end

  // Pending-event bits awaiting acceptance.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pending_r <= 8'd0;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Presentation FSM: next state and next event code.
  always_comb begin
    state_nxt_s = state_r;
    code_nxt_s  = code_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_r != 8'd0) begin
          code_nxt_s  = lowest_index(pending_r);
          state_nxt_s = ST_SHOW;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (accept_s) begin
          if (pending_nxt_s != 8'd0) begin
            code_nxt_s  = lowest_index(pending_nxt_s);
            state_nxt_s = ST_SHOW;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        code_nxt_s  = 3'd0;
      end
    endcase
  end

  // FSM state plus registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      code_r  <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s == ST_SHOW);
      code_r  <= code_nxt_s;
    end
  end

  assign evt.evt_valid   = valid_r;
  assign evt.evt_code    = code_r;
  assign frame_hit_mask  = fired_r;
  assign last_frame_mask = last_r;

`ifdef COLL_DROP_COUNT_EN
  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] popcount8(input logic [7:0] vec);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, vec[i]};
    end
    return cnt;
  endfunction

  logic [7:0] drop_s;
  logic [8:0] drop_sum_s;
  logic [7:0] drop_count_r;

  assign drop_s     = new_hit_s & pending_r & ~clear_s;
  assign drop_sum_s = {1'b0, drop_count_r} + {5'd0, popcount8(drop_s)};

  // Saturating count of hits lost to a still-pending event of the same source.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      drop_count_r <= 8'd0;
    end else if (drop_sum_s[8]) begin
      drop_count_r <= 8'hFF;
    end else begin
      drop_count_r <= drop_sum_s[7:0];
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: doc/collision_event_arbiter.md
COLLISION_EVENT_ARBITER -- requirements
Module: collision_event_arbiter

Interface
REQ-001 SHALL have ports, one per line (name, direction, width, meaning):
 clk  input  1  system clock; one clock domain
 resetN  input  1  reset, synchronous, active-low
 startOfFrame  input  1  one-cycle pulse at start of each frame
 towerPlayerCollision  input  1  player/tower pixel overlap (source 0)
 TowerEnemyHUCollision  input  1  enemy-HU/tower pixel overlap (source 1)
 ShotEnemyCollision  input  3  per-shot shot/enemy overlap, bit i = source 2+i
 ShotBoxCollision  input  3  per-shot shot/tower overlap, bit i = source 5+i
 evt_ready  input  1  consumer accepts current event
 evt_valid  output  1  event presented
 evt_code  output  3  source index 0..7 of presented event
 frame_hit_mask  output  8  sources hit so far in current frame
 last_frame_mask  output  8  frame_hit_mask snapshot at last startOfFrame
 drop_count  output  8  dropped-event counter (see Configuration)
REQ-002 SHALL use one clock (clk); reset SHALL be synchronous and active-low (resetN).

Function
REQ-003 src[7:0] = {ShotBoxCollision, ShotEnemyCollision, TowerEnemyHUCollision, towerPlayerCollision}, bit 0 = towerPlayerCollision.
REQ-004 fired[i] SHALL set on the edge where src[i]=1; cleared at the edge where startOfFrame=1; frame_hit_mask = fired.
REQ-005 A source SHALL generate at most one event per frame: new_hit[i] = src[i] & (~fired[i] | startOfFrame).
REQ-006 startOfFrame and src[i] in same cycle: hit belongs to new frame; fired[i] ends at 1, new_hit[i]=1.
REQ-007 last_frame_mask SHALL load fired (pre-clear value) on each startOfFrame edge.
REQ-008 pending[i] SHALL set on new_hit[i]; clear on accept (evt_valid & evt_ready) when evt_code=i; set beats clear in same cycle.
REQ-009 new_hit[i] while pending[i]=1 and not cleared that cycle SHALL be a drop (pending unchanged).
REQ-010 FSM states IDLE, SHOW; reset state IDLE.
REQ-011 IDLE: if pending!=0, load evt_code = lowest set pending index, go SHOW; else stay.
REQ-012 SHOW: evt_valid=1; evt_code stable until accept.
REQ-013 SHOW on accept: if (pending with accepted bit cleared, plus new_hit) !=0, load lowest index of that set, stay SHOW (back-to-back, no idle cycle); else go IDLE.
REQ-014 Priority fixed: lower index wins (player > enemy-HU > shot-enemy 0..2 > shot-box 0..2).
REQ-015 Latency: src[i] high in cycle N (IDLE, no other pending) -> evt_valid=1, evt_code=i in cycle N+2.
REQ-016 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-017 On resetN=0 at clk edge: fired, pending, last_frame_mask, drop_count = 0; FSM IDLE; evt_valid=0; evt_code=0.
REQ-018 Reset mid-SHOW SHALL abandon the event with no accept side effects.

Configuration
REQ-019 Macro COLL_DROP_COUNT_EN defined: drop_count increments by 1 per dropped source per cycle (multiple simultaneous drops add their count), saturating at 255, cleared only by reset.
REQ-020 Macro undefined: drop_count tied to 0, no counter logic; all else identical.

Verification
REQ-021 Reset, then towerPlayerCollision=1 cycle N, evt_ready=1 -> evt_valid=1 evt_code=0 at N+2, evt_valid=0 at N+3.
REQ-022 Same cycle src=8'b1010_0010, evt_ready=0 -> evt_code=1; then hold evt_ready=1 -> codes 1,5,7 on consecutive cycles, then evt_valid=0.
REQ-023 towerPlayerCollision held high 100 cycles in one frame -> exactly one event; frame_hit_mask=8'h01; after startOfFrame last_frame_mask=8'h01, frame_hit_mask=8'h00.
REQ-024 evt_ready=0; ShotEnemyCollision[0] hit in frames 1,2,3 -> one pending event code 2; drop_count=2 (with macro), 0 (without).
REQ-025 startOfFrame coincident with ShotBoxCollision[2] after same source hit previous frame (accepted) -> new event code 7.
REQ-026 resetN=0 for one cycle while evt_valid=1 -> next cycle evt_valid=0, all masks 8'h00, drop_count=0.
